al_buckeye_seq: RTL and testbench
=================================

# al_buckeye_seq

Sequencer and arbiter in front of the Buckeye auto-load engine. Takes whole load frames from two word-stream requesters (BPI flash readback and JTAG) plus a default-load request, and grants one at a time. Buffers the granted frame locally, clears the engine's done flag, bursts the frame into the engine FIFO as back-to-back CAPTURE strobes, then supervises completion with a timeout. Sits between the BPI/JTAG register interfaces and the Buckeye loader, in the CLK40 domain.

## Interface
- NWORDS, 18: words per frame (6 chips × 48 bits / 16); legal range 1..32.
- TMO_CYC, 24000: CLK40 cycles allowed from the end of the burst to AL_DONE.
- CLK40  in  1  system clock; all logic on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- BPI_VLD / BPI_LAST / BPI_DATA  in  1/1/16  BPI word stream; LAST marks the final word of a frame.
- BPI_RDY  out  1  word accepted when VLD&RDY.
- JTAG_VLD / JTAG_LAST / JTAG_DATA  in  1/1/16  JTAG word stream, same rules.
- JTAG_RDY  out  1  JTAG accept.
- DFLT_REQ  in  1  one-cycle pulse; requests an all-zero default load.
- CLR_ERR  in  1  pulse; clears ERR_LEN and ERR_TMO.
- AL_DONE  in  1  engine done flag.
- AL_BKY_ENA  in  1  engine busy.
- CAPTURE  out  1  engine FIFO write strobe.
- AL_WORD  out  16  data qualified by CAPTURE.
- LOAD_DFLT  out  1  one-cycle default-load strobe.
- CLR_AL_DONE  out  1  one-cycle strobe that clears the engine done flag.
- BUSY  out  1  high in any state except IDLE.
- GNT_SRC  out  2  current/last grant: 0 none, 1 BPI, 2 JTAG, 3 DFLT.
- STAT_OK  out  1  last load completed without error.
- ERR_LEN  out  1  sticky frame-length error.
- ERR_TMO  out  1  sticky timeout error.
- LOAD_CNT  out  8  successful loads; wraps at 255→0.

## Operation
- Reset values: every output is 0, except GNT_SRC, which is 0 (none). The FSM resets to IDLE and clears the DFLT pending flag.
- DFLT_REQ sets a pending flag. The flag clears when its grant is issued.
- Arbitration happens only in IDLE, and only when AL_BKY_ENA=0. Priority is JTAG_VLD > DFLT pending > BPI_VLD, fixed with no rotation.
- IDLE → FILL for a stream grant; IDLE → CLR for DFLT.
- FILL:
  - RDY is high for the granted source only.
  - Each accepted word is written to buffer[idx], then idx increments.
  - LAST on word idx = NWORDS-1 → CLR.
  - LAST before NWORDS words → ERR_LEN=1, frame discarded, → IDLE.
  - Word NWORDS-1 accepted without LAST → ERR_LEN=1, → DRAIN.
- DRAIN: RDY stays high; words are discarded until LAST is accepted; → IDLE. No load is issued.
- CLR: CLR_AL_DONE=1 for 1 cycle → GAP.
- GAP: 1 idle cycle, so the engine's done flag is low before the first strobe. Then → BURST (stream) or DFLT.
- BURST: CAPTURE=1 for exactly NWORDS consecutive cycles, with AL_WORD = buffer[0..NWORDS-1] in order. → WAIT.
- DFLT: LOAD_DFLT=1 for 1 cycle → WAIT.
- WAIT:
  - The timer counts from 0.
  - AL_DONE=1 → DONE.
  - Timer = TMO_CYC-1 → ERR_TMO=1, STAT_OK=0, → IDLE.
- DONE: STAT_OK=1, LOAD_CNT+1, → IDLE.
- After a timeout the next grant is held off until AL_BKY_ENA falls, which happens naturally through the IDLE arbitration rule.
- Requests arriving while BUSY wait:
  - Streams are held by VLD.
  - DFLT is held by its pending flag.
  - A second DFLT_REQ while one is already pending is merged into it.
- CLR_ERR clears only the errors; it does not touch the FSM. If CLR_ERR coincides with an error set, the set wins.
- STAT_OK clears at every new grant.

## Timing
- Arbitration to RDY: 1 cycle. The grant registers in IDLE, and RDY goes high on the first FILL cycle.
- Last accepted word to first CAPTURE: 3 cycles (CLR, GAP, then BURST cycle 0).
- DFLT grant to LOAD_DFLT: 3 cycles (CLR, GAP, DFLT).
- AL_DONE sampled high to BUSY low: 2 cycles (DONE, IDLE).
- AL_WORD and CAPTURE are registered outputs.
- RST mid-frame: the buffer contents are don't-care, all strobes drop immediately, and no partial burst resumes.

## Structure
- Package al_seq_pkg holds:
  - the state enum (IDLE, FILL, DRAIN, CLR, GAP, BURST, DFLT, WAIT, DONE);
  - the GNT_SRC codes;
  - the default NWORDS and TMO_CYC constants.
- Sub-module al_seq_buf: a 32×16 register-file buffer with a write port (we, waddr, wdata) and a registered read port (raddr → rdata, 1-cycle latency). The read address is pre-issued one cycle ahead so CAPTURE stays contiguous.

## Test plan
- BPI frame of 18 words 0x0001..0x0012, LAST on word 18 → CLR_AL_DONE pulse, one gap cycle, then 18 contiguous CAPTUREs carrying 0x0001..0x0012. AL_DONE driven 100 cycles later → STAT_OK=1, LOAD_CNT=1.
- JTAG_VLD and BPI_VLD high together in IDLE → JTAG_RDY granted, GNT_SRC=2. BPI is served next, and LOAD_CNT=2 after both complete.
- DFLT_REQ pulse → CLR_AL_DONE, then LOAD_DFLT three cycles after the grant, with no CAPTURE. AL_DONE → LOAD_CNT+1, GNT_SRC=3.
- Frame lengths:
  - 10-word BPI frame → ERR_LEN=1, no CAPTURE, BUSY low.
  - 20-word frame → ERR_LEN=1, all 20 words accepted, no CAPTURE.
- AL_DONE never asserted → ERR_TMO=1 after 24000 WAIT cycles. A new request is held until AL_BKY_ENA=0. CLR_ERR → ERR_TMO=0.
- RST asserted mid-BURST at word 9 → CAPTURE=0 in the same cycle, all outputs at reset values. The next frame loads all 18 words correctly.

Source files
------------

// File: rtl/al_seq_pkg.sv
// Shared types and defaults for the Buckeye auto-load sequencer.
// State and grant encodings live here so the bench and RTL agree on them.
package al_seq_pkg;

   localparam int NWORDS_DFLT  = 18;
   localparam int TMO_CYC_DFLT = 24000;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_FILL,
      ST_DRAIN,
      ST_CLR,
      ST_GAP,
      ST_BURST,
      ST_DFLT,
      ST_WAIT,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_BPI  = 2'd1,
      GNT_JTAG = 2'd2,
      GNT_DFLT = 2'd3
   } gnt_t;

endpackage

// File: rtl/al_seq_buf.sv
// 32x16 frame buffer: one write port, and a read port with a registered output
// so the burst can pre-issue its address one cycle ahead.
module al_seq_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [15:0] wdata,
   input  logic        re,
   input  logic [4:0]  raddr,
   output logic [15:0] rdata
);

   logic [15:0] mem [32];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Only the read register is reset; it drives AL_WORD directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/al_buckeye_seq.sv
// Arbitrates BPI / JTAG / default-load requests, buffers one frame, and bursts
// it into the Buckeye auto-load engine, then supervises AL_DONE with a timeout.
module al_buckeye_seq
   import al_seq_pkg::*;
#(
   parameter int NWORDS  = NWORDS_DFLT,
   parameter int TMO_CYC = TMO_CYC_DFLT
) (
   input  logic        CLK40,
   input  logic        RST,
   input  logic        BPI_VLD,
   input  logic        BPI_LAST,
   input  logic [15:0] BPI_DATA,
   output logic        BPI_RDY,
   input  logic        JTAG_VLD,
   input  logic        JTAG_LAST,
   input  logic [15:0] JTAG_DATA,
   output logic        JTAG_RDY,
   input  logic        DFLT_REQ,
   input  logic        CLR_ERR,
   input  logic        AL_DONE,
   input  logic        AL_BKY_ENA,
   output logic        CAPTURE,
   output logic [15:0] AL_WORD,
   output logic        LOAD_DFLT,
   output logic        CLR_AL_DONE,
   output logic        BUSY,
   output logic [1:0]  GNT_SRC,
   output logic        STAT_OK,
   output logic        ERR_LEN,
   output logic        ERR_TMO,
   output logic [7:0]  LOAD_CNT
);

   localparam int              TW       = $clog2(TMO_CYC + 1);
   localparam logic [4:0]      LAST_IDX = 5'(NWORDS - 1);
   localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);

   state_t        state;
   gnt_t          gnt;
   logic [4:0]    idx;
   logic [TW-1:0] tmr;
   logic          pend;

   logic          s_vld;
   logic          s_last;
   logic [15:0]   s_data;
   logic          rdy;
   logic          acc;

   // Stream handshake: a word moves on a cycle where VLD and RDY are both high.
   always_comb begin
      s_vld  = (gnt == GNT_JTAG) ? JTAG_VLD  : BPI_VLD;
      s_last = (gnt == GNT_JTAG) ? JTAG_LAST : BPI_LAST;
      s_data = (gnt == GNT_JTAG) ? JTAG_DATA : BPI_DATA;
      rdy    = (state == ST_FILL) || (state == ST_DRAIN);
      acc    = rdy && s_vld;
   end

   assign BPI_RDY  = rdy && (gnt == GNT_BPI);
   assign JTAG_RDY = rdy && (gnt == GNT_JTAG);
   assign BUSY     = (state != ST_IDLE);
   assign GNT_SRC  = gnt;

   al_seq_buf u_buf (
      .clk   (CLK40),
      .rst   (RST),
      .we    ((state == ST_FILL) && acc),
      .waddr (idx),
      .wdata (s_data),
      .re    ((state == ST_GAP) || (state == ST_BURST)),
      .raddr ((state == ST_BURST) ? idx + 5'd1 : 5'd0),
      .rdata (AL_WORD)
   );

   always_ff @(posedge CLK40 or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         gnt         <= GNT_NONE;
         idx         <= '0;
         tmr         <= '0;
         pend        <= 1'b0;
         CAPTURE     <= 1'b0;
         LOAD_DFLT   <= 1'b0;
         CLR_AL_DONE <= 1'b0;
         STAT_OK     <= 1'b0;
         ERR_LEN     <= 1'b0;
         ERR_TMO     <= 1'b0;
         LOAD_CNT    <= '0;
      end else begin
         CAPTURE     <= 1'b0;
         LOAD_DFLT   <= 1'b0;
         CLR_AL_DONE <= 1'b0;
         if (DFLT_REQ) pend <= 1'b1;
         // Error sets below come later in this block, so they win over a clear.
         if (CLR_ERR) begin
            ERR_LEN <= 1'b0;
            ERR_TMO <= 1'b0;
         end
         case (state)
            ST_IDLE: if (!AL_BKY_ENA) begin
               idx <= '0;
               if (JTAG_VLD) begin
                  gnt <= GNT_JTAG; STAT_OK <= 1'b0; state <= ST_FILL;
               end else if (pend) begin
                  gnt <= GNT_DFLT; STAT_OK <= 1'b0; pend <= DFLT_REQ;
                  CLR_AL_DONE <= 1'b1; state <= ST_CLR;
               end else if (BPI_VLD) begin
                  gnt <= GNT_BPI; STAT_OK <= 1'b0; state <= ST_FILL;
               end
            end
            ST_FILL: if (acc) begin
               if (s_last) begin
                  if (idx == LAST_IDX) begin
                     CLR_AL_DONE <= 1'b1; state <= ST_CLR;
                  end else begin
                     ERR_LEN <= 1'b1; state <= ST_IDLE;
                  end
               end else if (idx == LAST_IDX) begin
                  ERR_LEN <= 1'b1; state <= ST_DRAIN;
               end else begin
                  idx <= idx + 5'd1;
               end
            end
            ST_DRAIN: if (acc && s_last) state <= ST_IDLE;
            ST_CLR:   state <= ST_GAP;
            ST_GAP: begin
               idx <= '0;
               tmr <= '0;
               if (gnt == GNT_DFLT) begin
                  LOAD_DFLT <= 1'b1; state <= ST_DFLT;
               end else begin
                  CAPTURE <= 1'b1; state <= ST_BURST;
               end
            end
            ST_BURST: begin
               if (idx == LAST_IDX) state <= ST_WAIT;
               else begin
                  idx <= idx + 5'd1; CAPTURE <= 1'b1;
               end
            end
            ST_DFLT: state <= ST_WAIT;
            ST_WAIT: begin
               if (AL_DONE) state <= ST_DONE;
               else if (tmr == TMO_LAST) begin
                  ERR_TMO <= 1'b1; STAT_OK <= 1'b0; state <= ST_IDLE;
               end else tmr <= tmr + 1'b1;
            end
            ST_DONE: begin
               STAT_OK  <= 1'b1;
               LOAD_CNT <= LOAD_CNT + 8'd1;
               state    <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_al_buckeye_seq.sv
// Directed bench for al_buckeye_seq: frame loads, arbitration, default load,
// length errors, timeout hold-off and mid-burst reset.
module tb_al_buckeye_seq;

   logic        CLK40 = 1'b0;
   logic        RST;
   logic        BPI_VLD, BPI_LAST, JTAG_VLD, JTAG_LAST;
   logic [15:0] BPI_DATA, JTAG_DATA;
   logic        BPI_RDY, JTAG_RDY;
   logic        DFLT_REQ, CLR_ERR, AL_DONE, AL_BKY_ENA;
   logic        CAPTURE, LOAD_DFLT, CLR_AL_DONE, BUSY, STAT_OK, ERR_LEN, ERR_TMO;
   logic [15:0] AL_WORD;
   logic [1:0]  GNT_SRC;
   logic [7:0]  LOAD_CNT;

   int tests = 0;
   int fails = 0;
   int n_acc;
   int caps;
   int cyc;

   al_buckeye_seq dut (
      .CLK40(CLK40), .RST(RST),
      .BPI_VLD(BPI_VLD), .BPI_LAST(BPI_LAST), .BPI_DATA(BPI_DATA), .BPI_RDY(BPI_RDY),
      .JTAG_VLD(JTAG_VLD), .JTAG_LAST(JTAG_LAST), .JTAG_DATA(JTAG_DATA), .JTAG_RDY(JTAG_RDY),
      .DFLT_REQ(DFLT_REQ), .CLR_ERR(CLR_ERR), .AL_DONE(AL_DONE), .AL_BKY_ENA(AL_BKY_ENA),
      .CAPTURE(CAPTURE), .AL_WORD(AL_WORD), .LOAD_DFLT(LOAD_DFLT), .CLR_AL_DONE(CLR_AL_DONE),
      .BUSY(BUSY), .GNT_SRC(GNT_SRC), .STAT_OK(STAT_OK), .ERR_LEN(ERR_LEN),
      .ERR_TMO(ERR_TMO), .LOAD_CNT(LOAD_CNT)
   );

   always #12 CLK40 = ~CLK40;

   initial begin
      #5000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK40);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic jtag, input logic vld, input logic last, input logic [15:0] data);
      if (jtag) begin
         JTAG_VLD = vld; JTAG_LAST = last; JTAG_DATA = data;
      end else begin
         BPI_VLD = vld; BPI_LAST = last; BPI_DATA = data;
      end
   endtask

   // Streams n words base, base+1, ...; LAST on word last_at (1-based, 0 = none).
   task automatic send_frame(input logic jtag, input int n, input int last_at,
                             input logic [15:0] base, output int acc_cnt);
      acc_cnt = 0;
      for (int i = 0; i < n; i++) begin
         int wc;
         wc = 0;
         drive(jtag, 1'b1, (i == last_at - 1), 16'(base + i));
         while (!(jtag ? JTAG_RDY : BPI_RDY) && wc < 200) begin
            tick();
            wc++;
         end
         if (wc >= 200) begin
            chk("rdy_wait", 32'(wc), 32'd0);
            break;
         end
         tick();
         acc_cnt++;
      end
      drive(jtag, 1'b0, 1'b0, 16'h0000);
   endtask

   // Entered on the cycle after the last word is accepted (CLR state).
   task automatic expect_burst(input logic [15:0] base);
      chk("clr_pulse", CLR_AL_DONE, 1'b1);
      chk("clr_no_cap", CAPTURE, 1'b0);
      tick();
      chk("gap_clr_low", CLR_AL_DONE, 1'b0);
      chk("gap_no_cap", CAPTURE, 1'b0);
      for (int k = 0; k < 18; k++) begin
         tick();
         chk("burst_cap", CAPTURE, 1'b1);
         chk("burst_word", AL_WORD, 32'(16'(base + k)));
      end
      tick();
      chk("burst_end", CAPTURE, 1'b0);
   endtask

   task automatic finish_load(input int gap, input logic [7:0] exp_cnt);
      repeat (gap) tick();
      AL_DONE = 1'b1;
      tick();
      AL_DONE = 1'b0;
      chk("done_busy", BUSY, 1'b1);
      tick();
      chk("idle_busy", BUSY, 1'b0);
      chk("stat_ok", STAT_OK, 1'b1);
      chk("load_cnt", LOAD_CNT, exp_cnt);
   endtask

   task automatic check_reset_outs();
      chk("rst_capture", CAPTURE, 1'b0);
      chk("rst_word", AL_WORD, 16'h0000);
      chk("rst_load_dflt", LOAD_DFLT, 1'b0);
      chk("rst_clr_done", CLR_AL_DONE, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_gnt", GNT_SRC, 2'd0);
      chk("rst_stat_ok", STAT_OK, 1'b0);
      chk("rst_err_len", ERR_LEN, 1'b0);
      chk("rst_err_tmo", ERR_TMO, 1'b0);
      chk("rst_load_cnt", LOAD_CNT, 8'd0);
      chk("rst_bpi_rdy", BPI_RDY, 1'b0);
      chk("rst_jtag_rdy", JTAG_RDY, 1'b0);
   endtask

   task automatic count_caps(input int n, output int c);
      c = 0;
      for (int i = 0; i < n; i++) begin
         if (CAPTURE) c++;
         tick();
      end
   endtask

   task automatic pulse_clr_err();
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
   endtask

   initial begin
      RST = 1'b1;
      BPI_VLD = 0; BPI_LAST = 0; BPI_DATA = '0;
      JTAG_VLD = 0; JTAG_LAST = 0; JTAG_DATA = '0;
      DFLT_REQ = 0; CLR_ERR = 0; AL_DONE = 0; AL_BKY_ENA = 0;
      tick();
      tick();
      check_reset_outs();
      RST = 1'b0;
      tick();

      // Basic BPI frame, done 100 cycles after the burst.
      send_frame(1'b0, 18, 18, 16'h0001, n_acc);
      chk("bpi_acc", n_acc, 18);
      expect_burst(16'h0001);
      finish_load(100, 8'd1);
      chk("bpi_gnt", GNT_SRC, 2'd1);

      // JTAG beats BPI when both are valid in IDLE.
      BPI_VLD = 1'b1; BPI_DATA = 16'h0B00; BPI_LAST = 1'b0;
      JTAG_VLD = 1'b1; JTAG_DATA = 16'h0A00; JTAG_LAST = 1'b0;
      tick();
      chk("arb_jtag_rdy", JTAG_RDY, 1'b1);
      chk("arb_bpi_rdy", BPI_RDY, 1'b0);
      chk("arb_gnt", GNT_SRC, 2'd2);
      send_frame(1'b1, 18, 18, 16'h0A00, n_acc);
      expect_burst(16'h0A00);
      finish_load(5, 8'd2);
      send_frame(1'b0, 18, 18, 16'h0B00, n_acc);
      chk("arb_bpi_gnt", GNT_SRC, 2'd1);
      expect_burst(16'h0B00);
      finish_load(5, 8'd3);

      // Default load: CLR, GAP, then LOAD_DFLT, no CAPTURE.
      DFLT_REQ = 1'b1;
      tick();
      DFLT_REQ = 1'b0;
      tick();
      chk("dflt_clr", CLR_AL_DONE, 1'b1);
      chk("dflt_gnt", GNT_SRC, 2'd3);
      chk("dflt_stat_cleared", STAT_OK, 1'b0);
      tick();
      chk("dflt_gap", LOAD_DFLT, 1'b0);
      tick();
      chk("dflt_strobe", LOAD_DFLT, 1'b1);
      chk("dflt_no_cap", CAPTURE, 1'b0);
      tick();
      chk("dflt_strobe_end", LOAD_DFLT, 1'b0);
      finish_load(5, 8'd4);
      chk("dflt_gnt_after", GNT_SRC, 2'd3);

      // Short frame.
      send_frame(1'b0, 10, 10, 16'h0C00, n_acc);
      chk("short_acc", n_acc, 10);
      chk("short_err", ERR_LEN, 1'b1);
      chk("short_busy", BUSY, 1'b0);
      chk("short_stat", STAT_OK, 1'b0);
      count_caps(6, caps);
      chk("short_no_cap", caps, 0);
      pulse_clr_err();
      chk("short_clr_err", ERR_LEN, 1'b0);

      // Long frame: extra words drained.
      send_frame(1'b0, 20, 20, 16'h0D00, n_acc);
      chk("long_acc", n_acc, 20);
      chk("long_err", ERR_LEN, 1'b1);
      chk("long_busy", BUSY, 1'b0);
      count_caps(6, caps);
      chk("long_no_cap", caps, 0);
      chk("long_cnt", LOAD_CNT, 8'd4);
      pulse_clr_err();
      chk("long_clr_err", ERR_LEN, 1'b0);

      // Timeout with the engine still busy, then hold-off of the next grant.
      send_frame(1'b0, 18, 18, 16'h0E00, n_acc);
      expect_burst(16'h0E00);
      AL_BKY_ENA = 1'b1;
      cyc = 0;
      while (BUSY && cyc < 30000) begin
         tick();
         cyc++;
      end
      chk("tmo_cycles", cyc, 24000);
      chk("tmo_err", ERR_TMO, 1'b1);
      chk("tmo_stat", STAT_OK, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 16'h0F00);
      repeat (5) tick();
      chk("tmo_hold_rdy", JTAG_RDY, 1'b0);
      chk("tmo_hold_busy", BUSY, 1'b0);
      AL_BKY_ENA = 1'b0;
      tick();
      chk("tmo_release_rdy", JTAG_RDY, 1'b1);
      send_frame(1'b1, 18, 18, 16'h0F00, n_acc);
      expect_burst(16'h0F00);
      finish_load(3, 8'd5);
      chk("tmo_sticky", ERR_TMO, 1'b1);
      pulse_clr_err();
      chk("tmo_clr_err", ERR_TMO, 1'b0);

      // Reset in the middle of a burst.
      send_frame(1'b0, 18, 18, 16'h1000, n_acc);
      chk("mid_clr", CLR_AL_DONE, 1'b1);
      tick();
      repeat (9) tick();
      chk("mid_cap", CAPTURE, 1'b1);
      chk("mid_word", AL_WORD, 16'h1008);
      RST = 1'b1;
      #1;
      check_reset_outs();
      tick();
      tick();
      RST = 1'b0;
      count_caps(4, caps);
      chk("post_rst_no_cap", caps, 0);
      chk("post_rst_busy", BUSY, 1'b0);
      send_frame(1'b0, 18, 18, 16'h1100, n_acc);
      expect_burst(16'h1100);
      finish_load(10, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
